// File: rtl/program_counter_rs_pkg.sv
// Shared types and helpers for the SAP program counter with return-address stack.
// Optional feature macro: PC_RELATIVE_EN (relative branch op PC_REL).
package sap_pc_pkg;

  localparam int unsigned PC_WIDTH_DEF       = 4;
  localparam int unsigned PC_STACK_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_JUMP,
    PC_CALL,
    PC_RET,
    PC_REL
  } pc_op_e;

  // Fixed priority: CALL > JUMP > RET > REL > INC > HOLD. Inputs are active-high requests.
  function automatic pc_op_e pc_decode(input logic call, input logic jump, input logic ret,
                                       input logic rel, input logic inc);
    if (call)      return PC_CALL;
    else if (jump) return PC_JUMP;
    else if (ret)  return PC_RET;
    else if (rel)  return PC_REL;
    else if (inc)  return PC_INC;
    else           return PC_HOLD;
  endfunction

endpackage

// File: rtl/program_counter_rs_return_stack.sv
// LIFO return-address stack: push writes din at sp, pop exposes the entry at sp-1.
// The caller never issues push and pop in the same cycle.
module return_stack
  import sap_pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH_DEF,
  parameter int unsigned DEPTH = PC_STACK_DEPTH_DEF,
  parameter int unsigned SPW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [SPW-1:0]   sp,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [2**AW];

  // Next stack pointer from push/pop requests.
  always_comb begin
    sp_d = sp_q;
    if (push && !full)      sp_d = sp_q + SPW'(1);
    else if (pop && !empty) sp_d = sp_q - SPW'(1);
  end

  // Stack pointer register; cleared asynchronously.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) sp_q <= '0;
    else          sp_q <= sp_d;
  end

  // Entry storage; contents after reset are don't-care so no reset is applied.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[AW'(sp_q)] <= din;
  end

  assign dout  = mem_q[AW'(sp_q - SPW'(1))];
  assign sp    = sp_q;
  assign full  = (sp_q == SPW'(DEPTH));
  assign empty = (sp_q == '0);

endmodule

// File: rtl/program_counter_rs.sv
// SAP program counter with CALL/RET return-address stack, bus output and ripple-carry out.
// Optional macro PC_RELATIVE_EN adds rel_n: PC <= PC + signed bus_in.
module program_counter_rs
  import sap_pc_pkg::*;
#(
  parameter int unsigned WIDTH       = PC_WIDTH_DEF,
  parameter int unsigned STACK_DEPTH = PC_STACK_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             enable,
  input  logic             jump_n,
  input  logic             call_n,
  input  logic             ret_n,
`ifdef PC_RELATIVE_EN
  input  logic             rel_n,
`endif
  input  logic [WIDTH-1:0] bus_in,
  input  logic             bus_enable_n,
  output logic [WIDTH-1:0] instruction_pointer,
  output logic [WIDTH-1:0] bus_out,
  output logic             rco,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_error
);

  localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);

  pc_op_e           op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             err_q, err_d;
  logic             push, pop;
  logic [WIDTH-1:0] ret_addr;
  logic [SPW-1:0]   sp;
  logic             rs_full, rs_empty;
  logic             rel_req;

`ifdef PC_RELATIVE_EN
  assign rel_req = ~rel_n;
`else
  assign rel_req = 1'b0;
`endif

  assign op = pc_decode(~call_n, ~jump_n, ~ret_n, rel_req, enable);

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_rs (
    .clk     (clk),
    .clear_n (clear_n),
    .push    (push),
    .pop     (pop),
    .din     (pc_q + WIDTH'(1)),
    .dout    (ret_addr),
    .sp      (sp),
    .full    (rs_full),
    .empty   (rs_empty)
  );

  // Next PC, stack control and sticky error from the decoded operation.
  // A CALL on a full stack (or RET on an empty one) is consumed as an error and
  // holds the PC; it does not fall through to a lower-priority request.
  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    case (op)
      PC_INC:  pc_d = pc_q + WIDTH'(1);
      PC_JUMP: pc_d = bus_in;
      PC_CALL: begin
        if (rs_full) err_d = 1'b1;
        else begin
          push = 1'b1;
          pc_d = bus_in;
        end
      end
      PC_RET: begin
        if (rs_empty) err_d = 1'b1;
        else begin
          pop  = 1'b1;
          pc_d = ret_addr;
        end
      end
      // Same-width add is the sign-extended add modulo 2^WIDTH.
      PC_REL:  pc_d = pc_q + bus_in;
      default: pc_d = pc_q;
    endcase
  end

  // PC and sticky error registers; cleared asynchronously.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign instruction_pointer = pc_q;
  assign bus_out             = bus_enable_n ? '0 : pc_q;
  assign rco                 = enable & (&pc_q);
  assign stack_empty         = (sp == '0);
  assign stack_full          = (sp == SPW'(STACK_DEPTH));
  assign stack_error         = err_q;

endmodule

// File: tb/tb_program_counter_rs.sv
// Self-checking bench for program_counter_rs (WIDTH=4, STACK_DEPTH=4).
module tb_program_counter_rs;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         clear_n, enable, jump_n, call_n, ret_n, bus_enable_n;
  logic [W-1:0] bus_in, instruction_pointer, bus_out;
  logic         rco, stack_empty, stack_full, stack_error;
`ifdef PC_RELATIVE_EN
  logic         rel_n = 1'b1;
`endif

  always #5 clk = ~clk;

  program_counter_rs #(
    .WIDTH       (W),
    .STACK_DEPTH (D)
  ) dut (
    .clk                 (clk),
    .clear_n             (clear_n),
    .enable              (enable),
    .jump_n              (jump_n),
    .call_n              (call_n),
    .ret_n               (ret_n),
`ifdef PC_RELATIVE_EN
    .rel_n               (rel_n),
`endif
    .bus_in              (bus_in),
    .bus_enable_n        (bus_enable_n),
    .instruction_pointer (instruction_pointer),
    .bus_out             (bus_out),
    .rco                 (rco),
    .stack_empty         (stack_empty),
    .stack_full          (stack_full),
    .stack_error         (stack_error)
  );

  typedef struct packed {
    logic [W-1:0] pc;
    logic         empty;
    logic         full;
    logic         err;
    logic         rco;
  } exp_t;

  exp_t         sbq[$];
  exp_t         e, obs;
  int           checks = 0;
  int           failures = 0;

  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk [D];
  int           m_sp;
  logic         m_err;

  task automatic model_reset();
    m_pc  = '0;
    m_sp  = 0;
    m_err = 1'b0;
    sbq.delete();
  endtask

  // Reference behaviour for one clock edge, from the currently driven inputs.
  task automatic model_step();
    if (!call_n) begin
      if (m_sp == D) m_err = 1'b1;
      else begin
        m_stk[m_sp] = m_pc + 4'd1;
        m_sp++;
        m_pc = bus_in;
      end
    end else if (!jump_n) begin
      m_pc = bus_in;
    end else if (!ret_n) begin
      if (m_sp == 0) m_err = 1'b1;
      else begin
        m_sp--;
        m_pc = m_stk[m_sp];
      end
    end
`ifdef PC_RELATIVE_EN
    else if (!rel_n) m_pc = m_pc + bus_in;
`endif
    else if (enable) m_pc = m_pc + 4'd1;
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge state, sample after the edge.
  task automatic cycle(input logic en, input logic ca, input logic ju, input logic re,
                       input logic [W-1:0] b);
    enable = en; call_n = ca; jump_n = ju; ret_n = re; bus_in = b;
    model_step();
    sbq.push_back('{pc: m_pc, empty: (m_sp == 0), full: (m_sp == D), err: m_err,
                    rco: (en && (m_pc == 4'hF))});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable = 1'b0; call_n = 1'b1; jump_n = 1'b1; ret_n = 1'b1;
    bus_in = '0; bus_enable_n = 1'b1;
`ifdef PC_RELATIVE_EN
    rel_n = 1'b1;
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_n = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    clear_n = 1'b0;
    model_reset();
    #3;
    obs = {instruction_pointer, stack_empty, stack_full, stack_error, rco};
    e   = '{pc: 4'h0, empty: 1'b1, full: 1'b0, err: 1'b0, rco: 1'b0};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs, e);
    end
    checks++;
    if (bus_out !== 4'h0) begin
      failures++;
      $display("FAIL reset_bus_out got=%h exp=0", bus_out);
    end
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_inc();
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
      e   = sbq.pop_front();
      obs = {instruction_pointer, stack_empty, stack_full, stack_error, rco};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL inc[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_call_ret();
    logic [W-1:0] seq_b [3] = '{4'h3, 4'h9, 4'h0};
    logic         seq_c [3] = '{1'b1, 1'b0, 1'b1};
    logic         seq_j [3] = '{1'b0, 1'b1, 1'b1};
    logic         seq_r [3] = '{1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, seq_c[i], seq_j[i], seq_r[i], seq_b[i]);
      e   = sbq.pop_front();
      obs = {instruction_pointer, stack_empty, stack_full, stack_error, rco};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL call_ret[%0d] got=%h exp=%h", i, obs, e);
      end
    end
    checks++;
    if (instruction_pointer !== 4'h4) begin
      failures++;
      $display("FAIL ret_addr got=%h exp=4", instruction_pointer);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'(2 * i + 2));
      e   = sbq.pop_front();
      obs = {instruction_pointer, stack_empty, stack_full, stack_error, rco};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL overflow_call[%0d] got=%h exp=%h", i, obs, e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      e   = sbq.pop_front();
      obs = {instruction_pointer, stack_empty, stack_full, stack_error, rco};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL overflow_unwind[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    for (int i = 0; i < 4; i++) begin
      e   = sbq.pop_front();
      checks++;
      if (i == 3) begin
        obs = {instruction_pointer, stack_empty, stack_full, stack_error, rco};
        if (obs !== e) begin
          failures++;
          $display("FAIL underflow_sticky got=%h exp=%h", obs, e);
        end
      end else if (e.err !== 1'b1) begin
        failures++;
        $display("FAIL underflow_model[%0d] err exp=%b required=1", i, e.err);
      end
    end
    apply_reset();
    checks++;
    if (stack_error !== 1'b0) begin
      failures++;
      $display("FAIL underflow_clear got=%b exp=0", stack_error);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'h7);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'hC);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h5);
    for (int i = 0; i < 3; i++) begin
      e   = sbq.pop_front();
      checks++;
      if (i == 2) begin
        obs = {instruction_pointer, stack_empty, stack_full, stack_error, rco};
        if (obs !== e) begin
          failures++;
          $display("FAIL priority_final got=%h exp=%h", obs, e);
        end
      end else if (e.pc !== ((i == 0) ? 4'h7 : 4'hC)) begin
        failures++;
        $display("FAIL priority_model[%0d] pc=%h", i, e.pc);
      end
    end
    checks++;
    if (instruction_pointer !== 4'h1) begin
      failures++;
      $display("FAIL priority_ret got=%h exp=1", instruction_pointer);
    end
  endtask

  task automatic test_bus_async_reset();
    apply_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'hB);
    e = sbq.pop_front();
    bus_enable_n = 1'b0;
    #1;
    checks++;
    if (bus_out !== e.pc) begin
      failures++;
      $display("FAIL bus_drive got=%h exp=%h", bus_out, e.pc);
    end
    bus_enable_n = 1'b1;
    #1;
    checks++;
    if (bus_out !== 4'h0) begin
      failures++;
      $display("FAIL bus_release got=%h exp=0", bus_out);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h6);
    void'(sbq.pop_front());
    call_n = 1'b0; bus_in = 4'h5;
    #2;
    clear_n = 1'b0;
    model_reset();
    #1;
    obs = {instruction_pointer, stack_empty, stack_full, stack_error, rco};
    e   = '{pc: m_pc, empty: 1'b1, full: 1'b0, err: m_err, rco: 1'b0};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", obs, e);
    end
    @(posedge clk);
    #1;
    bus_enable_n = 1'b0;
    #1;
    checks++;
    if ({instruction_pointer, bus_out, stack_empty} !== {4'h0, 4'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_hold pc=%h bus=%h empty=%b exp=0 0 1",
               instruction_pointer, bus_out, stack_empty);
    end
    @(negedge clk);
    idle_inputs();
    clear_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

`ifdef PC_RELATIVE_EN
  task automatic test_rel();
    apply_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'hA);
    rel_n = 1'b0;
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'hE);
    rel_n = 1'b1;
    void'(sbq.pop_front());
    e = sbq.pop_front();
    checks++;
    if (instruction_pointer !== 4'h8 || e.pc !== 4'h8) begin
      failures++;
      $display("FAIL rel_branch got=%h exp=8", instruction_pointer);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_inc();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_priority();
    test_bus_async_reset();
`ifdef PC_RELATIVE_EN
    test_rel();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
